bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
- Sequential converter from packed BCD to unsigned binary, i.e. the inverse of the decimal-adjust path that packs binary into BCD digits.
- Accepts one packed BCD word per transaction over a valid/ready handshake.
- Converts MSD-first, one digit per clock, using acc = acc*10 + digit.
- Presents the binary result and an invalid-digit flag on a valid/ready output handshake; sits between BCD-formatted datapaths and binary arithmetic.

Parameters:
- DIGITS, 2, number of BCD digits in the input word (>= 1).
- BIN_W, 7, output width; must be >= ceil(log2(10^DIGITS)) (7 for DIGITS=2).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_bcd is valid
- in_ready  output  1  converter can accept a word
- in_bcd  input  4*DIGITS  packed BCD, digit i at bits [4i+3:4i], digit 0 least significant
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  BIN_W  binary result
- out_err  output  1  at least one input digit was > 9

Behaviour:
- Reset is asynchronous, active-low (rst_n); clk is the single clock.
- While rst_n=0, all state clears: state=IDLE, accumulator=0, digit counter=0, captured word=0, out_valid=0, out_data=0, out_err=0; in_ready=1 after reset release.
- State machine IDLE -> CONV -> DONE -> IDLE.
- IDLE:
  - in_ready=1, decoded from state only, with no combinational path from any input.
  - On an edge with in_valid=1: capture in_bcd, clear accumulator and err, set cnt=DIGITS-1, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge: d = captured digit[cnt]; acc <= trunc_BIN_W((acc<<3) + (acc<<1) + d), computed at BIN_W+4 bits; err <= err | (d > 9).
  - When cnt=0, go to DONE; otherwise cnt <= cnt-1.
- DONE:
  - out_valid=1; out_data and out_err are stable until handshake.
  - On an edge with out_ready=1: go to IDLE; out_valid drops on the following cycle.
- Latency: out_valid rises exactly DIGITS edges after the accepting edge.
- Throughput: one word per DIGITS+2 cycles when out_ready is held high.
- out_ready low in DONE: stall indefinitely, holding all outputs; no input is accepted.
- Invalid digits (A-F):
  - The conversion still completes with the digit's raw value; out_err=1.
  - out_data equals the modular result, with no saturation.
- in_valid while not in IDLE: ignored; the producer must hold it until in_ready.
- out_ready outside DONE: ignored.
- Reset asserted mid-CONV or in DONE: the transaction is dropped and no output is produced.
- out_data and out_err are registered, and equal their last values outside DONE. Only out_valid qualifies them.

Optional Feature:
- Macro: BCD_TO_BIN_SIGN_EN.
- Enabled:
  - Adds port in_neg (input, 1), captured with in_bcd.
  - out_data widens to BIN_W+1 bits.
  - In the DONE transition the result is two's-complement negated when in_neg=1, without adding latency.
  - Negative zero yields 0.
  - out_err is unaffected by in_neg.
- Disabled: no in_neg port; out_data is BIN_W bits unsigned.

Test Plan:
- DIGITS=2, in_bcd=8'h99 with in_valid for one cycle, out_ready=1 -> out_valid 2 edges after acceptance, out_data=7'd99, out_err=0, in_ready=1 one cycle after handshake.
- in_bcd=8'h00, then back-to-back 8'h42 with in_valid held high -> results 0 then 42 in order; the second word is accepted only when in_ready=1; spacing is 4 cycles.
- in_bcd=8'h17, out_ready=0 for 5 cycles then 1 -> out_valid, out_data=17 stable through the stall; in_ready stays 0; one result only.
- in_bcd=8'h3A -> out_err=1, out_data=7'd40; a following 8'h12 gives out_err=0, out_data=12 (err not sticky across transactions).
- Accept 8'h55, pulse rst_n low during CONV -> out_valid never rises, out_data=0, in_ready=1 after release; a next 8'h08 gives 8.
- With BCD_TO_BIN_SIGN_EN: in_bcd=8'h25, in_neg=1 -> out_data=8'hE7; in_bcd=8'h00, in_neg=1 -> 8'h00.

Source files
------------

// File: rtl/bcd_to_bin.sv
//------------------------------------------------------------------------------
// Module      : bcd_to_bin
// Description : Sequential packed-BCD to unsigned binary converter, MSD first,
//               one digit per clock, with valid/ready handshakes on both sides.
//               Optional signed output via macro BCD_TO_BIN_SIGN_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_to_bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
`ifdef BCD_TO_BIN_SIGN_EN
    input  logic                  in_neg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W:0]        out_data,
`else
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_data,
`endif
    output logic                  out_err
);

`ifdef BCD_TO_BIN_SIGN_EN
    localparam int OUT_W = BIN_W + 1;
`else
    localparam int OUT_W = BIN_W;
`endif
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 err_q, err_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;
    logic                 out_err_q, out_err_d;
`ifdef BCD_TO_BIN_SIGN_EN
    logic                 neg_q, neg_d;
`endif

    logic [3:0]           digit;
    logic [BIN_W-1:0]     mac;
    logic [OUT_W-1:0]     result;

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                digit = bcd_q[4*i +: 4];
            end
        end
    end

    // acc*10 + digit; truncation to BIN_W gives the modular result directly.
    assign mac = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

`ifdef BCD_TO_BIN_SIGN_EN
    assign result = neg_q ? (~{1'b0, mac} + OUT_W'(1)) : {1'b0, mac};
`else
    assign result = mac;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
`ifdef BCD_TO_BIN_SIGN_EN
        neg_d      = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bcd_d   = in_bcd;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_LAST;
`ifdef BCD_TO_BIN_SIGN_EN
                    neg_d   = in_neg;
`endif
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = mac;
                err_d = err_q | (digit > 4'd9);
                if (cnt_q == '0) begin
                    out_data_d = result;
                    out_err_d  = err_q | (digit > 4'd9);
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
`ifdef BCD_TO_BIN_SIGN_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
`ifdef BCD_TO_BIN_SIGN_EN
            neg_q      <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_to_bin
// Description : Self-checking bench for bcd_to_bin (DIGITS=2, BIN_W=7).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_to_bin;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;
`ifdef BCD_TO_BIN_SIGN_EN
    localparam int OUT_W  = BIN_W + 1;
`else
    localparam int OUT_W  = BIN_W;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*DIGITS-1:0]  in_bcd;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic                 out_err;
`ifdef BCD_TO_BIN_SIGN_EN
    logic                 in_neg;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
`ifdef BCD_TO_BIN_SIGN_EN
        .in_neg    (in_neg),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: value = sum(digit_i * 10^i) mod 2^BIN_W, optional negation.
    function automatic void model(input logic [4*DIGITS-1:0] bcd, input logic neg,
                                  output logic [OUT_W-1:0] d, output logic e);
        int v;
        int p;
        int dig;
        v = 0;
        p = 1;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = int'((bcd >> (4*i)) & 15);
            v   = v + dig * p;
            p   = p * 10;
            if (dig > 9) e = 1'b1;
        end
        v = v % (1 << BIN_W);
`ifdef BCD_TO_BIN_SIGN_EN
        if (neg) v = ((1 << OUT_W) - v) % (1 << OUT_W);
`else
        if (neg) v = v;
`endif
        d = OUT_W'(v);
    endfunction

    task automatic xfer(input logic [4*DIGITS-1:0] bcd, input logic neg,
                        input int stall, input string tag);
        logic [OUT_W-1:0] ed;
        logic             ee;
        int               g;
        model(bcd, neg, ed, ee);
        in_bcd    = bcd;
`ifdef BCD_TO_BIN_SIGN_EN
        in_neg    = neg;
`endif
        in_valid  = 1'b1;
        out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 20) begin
            step();
            g++;
        end
        chk({tag, " ready_before"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk({tag, " busy"}, in_ready, 1'b0);
        chk({tag, " early_valid"}, out_valid, 1'b0);
        repeat (DIGITS - 1) begin
            step();
            chk({tag, " early_valid"}, out_valid, 1'b0);
        end
        step();
        chk({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " data"}, out_data, ed);
        chk({tag, " err"}, out_err, ee);
        repeat (stall) begin
            step();
            chk({tag, " stall_valid"}, out_valid, 1'b1);
            chk({tag, " stall_data"}, out_data, ed);
            chk({tag, " stall_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, out_valid, 1'b0);
        chk({tag, " ready_after"}, in_ready, 1'b1);
        chk({tag, " data_hold"}, out_data, ed);
    endtask

    initial begin
        int acc_cyc[$];
        int res[$];
        int cyc;
        logic rdy, vld, ov;
        logic [OUT_W-1:0] od;
        logic [4*DIGITS-1:0] rb;
        logic rn;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
`ifdef BCD_TO_BIN_SIGN_EN
        in_neg    = 1'b0;
`endif
        step();
        step();
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data", out_data, OUT_W'(0));
        chk("rst out_err", out_err, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rst in_ready", in_ready, 1'b1);

        xfer(8'h99, 1'b0, 0, "bcd99");

        // Back-to-back: in_valid held high, consumer always ready.
        in_bcd    = 8'h00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            rdy = in_ready;
            vld = in_valid;
            ov  = out_valid;
            od  = out_data;
            step();
            cyc++;
            if (rdy && vld) begin
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 1) in_bcd = 8'h42;
                else in_valid = 1'b0;
            end
            if (ov) res.push_back(int'(od));
        end
        out_ready = 1'b0;
        chk("b2b n_results", res.size(), 2);
        chk("b2b n_accepts", acc_cyc.size(), 2);
        if (res.size() == 2) begin
            chk("b2b first", res[0], 0);
            chk("b2b second", res[1], 42);
        end
        if (acc_cyc.size() == 2) begin
            chk("b2b spacing", acc_cyc[1] - acc_cyc[0], DIGITS + 2);
        end

        xfer(8'h17, 1'b0, 5, "stall17");
        step();
        chk("stall17 single", out_valid, 1'b0);

        xfer(8'h3A, 1'b0, 0, "bad3A");
        xfer(8'h12, 1'b0, 0, "after_bad12");

        // Reset during CONV drops the word.
        in_bcd   = 8'h55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rstmid busy", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid out_valid", out_valid, 1'b0);
        chk("rstmid out_data", out_data, OUT_W'(0));
        chk("rstmid in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid no_output", out_valid, 1'b0);
        end
        chk("rstmid ready_after", in_ready, 1'b1);
        xfer(8'h08, 1'b0, 0, "post_rst08");

`ifdef BCD_TO_BIN_SIGN_EN
        xfer(8'h25, 1'b1, 0, "neg25");
        chk("neg25 value", out_data, 8'hE7);
        xfer(8'h00, 1'b1, 0, "neg00");
        chk("neg00 value", out_data, 8'h00);
`endif

        for (int i = 0; i < 24; i++) begin
            rb = (4*DIGITS)'($urandom);
`ifdef BCD_TO_BIN_SIGN_EN
            rn = 1'($urandom_range(0, 1));
`else
            rn = 1'b0;
`endif
            xfer(rb, rn, int'($urandom_range(0, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
